// File: rtl/gmii2rgmii_pkg.sv
// Shared definitions for the GMII-to-RGMII transmit converter: FSM states,
// idle code on the SDR stage and inter-frame-gap counter helpers.
package gmii2rgmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_HI_NIB,
        ST_IFG,
        ST_DROP
    } tx_state_t;

    localparam logic [4:0] IDLE_CODE   = 5'b0_0000;
    localparam int         IFG_MIN_DEF = 12;
    // Wide enough for 2*255-2 at 10/100.
    localparam int         IFG_CNT_W   = 9;

    // The first idle cycle is spent in XFER/DROP and one more on the way
    // out of IFG, hence the -2 in both modes.
    function automatic logic [IFG_CNT_W-1:0] ifg_load(input int ifg_min, input logic byte_mode);
        int cycles;
        cycles = byte_mode ? (ifg_min - 2) : (2 * ifg_min - 2);
        return IFG_CNT_W'(cycles);
    endfunction

    function automatic logic [4:0] sdr_code(input logic ctl, input logic [3:0] nib);
        return {ctl, nib};
    endfunction

endpackage

// File: rtl/gmii2rgmii_if.sv
// Byte-wide GMII transmit handshake between the frame generator and the
// RGMII converter; the source holds den/dout/err while rdy is low.
interface gmii2rgmii_if;

    logic       gmii_den;
    logic [7:0] gmii_dout;
    logic       gmii_err;
    logic       gmii_rdy;

    modport master (
        output gmii_den,
        output gmii_dout,
        output gmii_err,
        input  gmii_rdy
    );

    modport slave (
        input  gmii_den,
        input  gmii_dout,
        input  gmii_err,
        output gmii_rdy
    );

endinterface

// File: rtl/gmii2rgmii_oddr.sv
// DDR output register: d1 is driven while clk is high, d2 while clk is low,
// both captured on the same rising edge. Vendor primitive or behavioral.
module rgmii_oddr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q
);

`ifdef XILINX_ZYNC
    for (genvar i = 0; i < WIDTH; i++) begin : g_oddr
        ODDR #(
            .DDR_CLK_EDGE("SAME_EDGE"),
            .INIT        (1'b0),
            .SRTYPE      ("SYNC")
        ) u_oddr (
            .Q (q[i]),
            .C (clk),
            .CE(1'b1),
            .D1(d1[i]),
            .D2(d2[i]),
            .R (1'b0),
            .S (1'b0)
        );
    end
`elsif XILINX_SPARTAN6
    for (genvar i = 0; i < WIDTH; i++) begin : g_oddr
        ODDR2 #(
            .DDR_ALIGNMENT("C0"),
            .INIT         (1'b0),
            .SRTYPE       ("SYNC")
        ) u_oddr (
            .Q (q[i]),
            .C0(clk),
            .C1(~clk),
            .CE(1'b1),
            .D0(d1[i]),
            .D1(d2[i]),
            .R (1'b0),
            .S (1'b0)
        );
    end
`elsif ALTERA
    altddio_out #(
        .width(WIDTH)
    ) u_oddr (
        .datain_h(d1),
        .datain_l(d2),
        .outclock(clk),
        .dataout (q)
    );
`else
    logic [WIDTH-1:0] hi_p0;
    logic [WIDTH-1:0] lo_p0;

    always_ff @(posedge clk) begin
        hi_p0 <= d1;
        lo_p0 <= d2;
    end

    assign q = clk ? hi_p0 : lo_p0;
`endif

endmodule

// File: rtl/gmii2rgmii.sv
// GMII byte stream to RGMII DDR transmit: byte per cycle at 1G, nibble per
// cycle with back-pressure at 10/100; enforces IFG and drops on link loss.
module gmii2rgmii
    import gmii2rgmii_pkg::*;
#(
    parameter int IFG_MIN = IFG_MIN_DEF
) (
    input  logic         gmii_clk,
    input  logic         rst,
    input  logic         speed_1g,
    input  logic         phy_link_up,
    gmii2rgmii_if.slave  gmii,
    output logic         rgmii_txc,
    output logic         rgmii_den,
    output logic [3:0]   rgmii_dout
);

    tx_state_t            state, state_nxt;
    logic [IFG_CNT_W-1:0] ifg_cnt, ifg_cnt_nxt;
    logic                 spd, spd_nxt;
    logic [4:0]           tx_hi, tx_lo, tx_hi_nxt, tx_lo_nxt;
    logic [3:0]           nib_p0;
    logic                 err_p0;
    logic                 rdy_st;
    logic                 load_byte;
    logic                 byte_mode;
    logic [4:0]           txd_q;

    // The first byte of a frame uses the live speed pin; later bytes use the latched mode.
    assign byte_mode     = (state == ST_IDLE) ? speed_1g : spd;
    assign gmii.gmii_rdy = rdy_st & ~rst;

    always_comb begin
        state_nxt   = state;
        ifg_cnt_nxt = ifg_cnt;
        spd_nxt     = spd;
        tx_hi_nxt   = IDLE_CODE;
        tx_lo_nxt   = IDLE_CODE;
        rdy_st      = 1'b0;
        load_byte   = 1'b0;

        case (state)
            ST_IDLE: begin
                rdy_st = 1'b1;
                if (gmii.gmii_den) begin
                    spd_nxt = speed_1g;
                    if (phy_link_up) begin
                        load_byte = 1'b1;
                        state_nxt = speed_1g ? ST_XFER : ST_HI_NIB;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_XFER: begin
                rdy_st = 1'b1;
                if (!phy_link_up) begin
                    state_nxt = ST_DROP;
                end else if (gmii.gmii_den) begin
                    load_byte = 1'b1;
                    state_nxt = spd ? ST_XFER : ST_HI_NIB;
                end else begin
                    state_nxt   = ST_IFG;
                    ifg_cnt_nxt = ifg_load(IFG_MIN, spd);
                end
            end
            ST_HI_NIB: begin
                if (!phy_link_up) begin
                    state_nxt = ST_DROP;
                end else begin
                    tx_hi_nxt = sdr_code(1'b1, nib_p0);
                    tx_lo_nxt = sdr_code(~err_p0, nib_p0);
                    state_nxt = ST_XFER;
                end
            end
            ST_IFG: begin
                if (ifg_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ifg_cnt_nxt = ifg_cnt - IFG_CNT_W'(1);
                end
            end
            ST_DROP: begin
                rdy_st = 1'b1;
                if (!gmii.gmii_den) begin
                    state_nxt   = ST_IFG;
                    ifg_cnt_nxt = ifg_load(IFG_MIN, spd);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (load_byte) begin
            tx_hi_nxt = sdr_code(1'b1, gmii.gmii_dout[3:0]);
            tx_lo_nxt = sdr_code(~gmii.gmii_err,
                                 byte_mode ? gmii.gmii_dout[7:4] : gmii.gmii_dout[3:0]);
        end
    end

    // p0: control state and SDR half-cycle registers
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ifg_cnt <= '0;
            spd     <= 1'b1;
            tx_hi   <= IDLE_CODE;
            tx_lo   <= IDLE_CODE;
        end else begin
            state   <= state_nxt;
            ifg_cnt <= ifg_cnt_nxt;
            spd     <= spd_nxt;
            tx_hi   <= tx_hi_nxt;
            tx_lo   <= tx_lo_nxt;
        end
    end

    always_ff @(posedge gmii_clk) begin
        if (load_byte) begin
            nib_p0 <= gmii.gmii_dout[7:4];
            err_p0 <= gmii.gmii_err;
        end
    end

    // p1: DDR output stage, forwarded clock kept aligned with data
    rgmii_oddr #(
        .WIDTH(5)
    ) u_oddr_dat (
        .clk(gmii_clk),
        .d1 (tx_hi),
        .d2 (tx_lo),
        .q  (txd_q)
    );

    rgmii_oddr #(
        .WIDTH(1)
    ) u_oddr_clk (
        .clk(gmii_clk),
        .d1 (1'b1),
        .d2 (1'b0),
        .q  (rgmii_txc)
    );

    assign rgmii_den  = txd_q[4];
    assign rgmii_dout = txd_q[3:0];

endmodule

// File: tb/tb_gmii2rgmii.sv
// Bench for gmii2rgmii: vector table of single-byte frames, hand sequences for
// reset/IFG/link loss/speed change, and random frames against a scoreboard.
module tb_gmii2rgmii;

    localparam int IFG  = 12;
    localparam int MAXC = 20000;

    logic       clk;
    logic       rst;
    logic       speed_1g;
    logic       phy_link_up;
    logic       rgmii_txc;
    logic       rgmii_den;
    logic [3:0] rgmii_dout;

    gmii2rgmii_if gif ();

    gmii2rgmii #(
        .IFG_MIN(IFG)
    ) dut (
        .gmii_clk   (clk),
        .rst        (rst),
        .speed_1g   (speed_1g),
        .phy_link_up(phy_link_up),
        .gmii       (gif),
        .rgmii_txc  (rgmii_txc),
        .rgmii_den  (rgmii_den),
        .rgmii_dout (rgmii_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Wire capture: wr[n]/wf[n] = {TX_CTL, TXD} in the high/low half after edge n.
    logic [4:0] wr [0:MAXC-1];
    logic [4:0] wf [0:MAXC-1];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (cyc < MAXC) wr[cyc] = {rgmii_den, rgmii_dout};
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (cyc < MAXC) wf[cyc] = {rgmii_den, rgmii_dout};
    end

    typedef struct {
        int         fid;
        logic [7:0] d;
        logic       e;
        int         k;
        logic       m;
        logic       drop;
        logic       b2b;
    } acc_t;

    typedef struct {
        logic       spd;
        logic [7:0] d;
        logic       e;
        logic [9:0] w0;
        logic [9:0] w1;
    } vec_t;

    acc_t       lg[$];
    logic [7:0] cur_d[$];
    logic       cur_e[$];
    int         fid_ctr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [9:0] wire_at(input int c);
        if (c < 0 || c >= MAXC) return 10'bx;
        return {wr[c], wf[c]};
    endfunction

    // Expected {rise, fall} of one wire cycle carrying a byte.
    function automatic logic [9:0] exp_wire(input logic [7:0] d, input logic e,
                                            input logic m, input int half);
        if (m)              return {1'b1, d[3:0], ~e, d[7:4]};
        else if (half == 0) return {1'b1, d[3:0], ~e, d[3:0]};
        else                return {1'b1, d[7:4], ~e, d[7:4]};
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic e, output int k);
        bit got;
        got = 0;
        k   = -1;
        gif.gmii_den  = 1'b1;
        gif.gmii_dout = d;
        gif.gmii_err  = e;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (gif.gmii_rdy === 1'b1) begin
                @(posedge clk);
                #1;
                k   = cyc;
                got = 1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte=%0h", d);
        end
    endtask

    task automatic send_frame(input logic m, input int drop_at, input bit tog, input bit b2b);
        int   k;
        bit   r;
        acc_t a;
        speed_1g = m;
        foreach (cur_d[i]) begin
            if (i == drop_at) phy_link_up = 1'b0;
            send_byte(cur_d[i], cur_e[i], k);
            if (k < 0) begin
                gif.gmii_den = 1'b0;
                phy_link_up  = 1'b1;
                return;
            end
            a.fid  = fid_ctr;
            a.d    = cur_d[i];
            a.e    = cur_e[i];
            a.k    = k;
            a.m    = m;
            a.drop = (drop_at >= 0) && (i >= drop_at);
            a.b2b  = (i == 0) && b2b;
            lg.push_back(a);
            if (tog) speed_1g = 1'($urandom);
        end
        gif.gmii_den  = 1'b0;
        gif.gmii_dout = 8'($urandom);
        gif.gmii_err  = 1'($urandom);
        // The frame ends only once a den=0 cycle is presented while ready.
        r = 0;
        for (int t = 0; t < 20 && !r; t++) begin
            @(negedge clk);
            r = (gif.gmii_rdy === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!r) chk("frame_end_timeout", 32'd0, 32'd1);
        phy_link_up = 1'b1;
        fid_ctr++;
    endtask

    task automatic check_from(input int s);
        int last_real;
        int v;
        int f;
        int nonidle;
        int need;
        last_real = -1;
        for (int i = s; i < lg.size(); i++) begin
            if (i > s && lg[i].fid == lg[i-1].fid)
                chk($sformatf("spacing f%0d", lg[i].fid), lg[i].k - lg[i-1].k, lg[i].m ? 1 : 2);
            if (i > s && lg[i].fid != lg[i-1].fid) begin
                v    = lg[i-1].k + (lg[i-1].m ? 1 : 2);
                f    = lg[i].k + 1;
                need = IFG * (lg[i-1].m ? 1 : 2);
                nonidle = 0;
                for (int c = ((last_real < 0) ? v : last_real) + 1; c < f; c++)
                    if (wire_at(c) !== 10'd0) nonidle++;
                chk($sformatf("gap_idle f%0d", lg[i].fid), nonidle, 0);
                if (lg[i].b2b) chk($sformatf("gap_len f%0d", lg[i].fid), f - v - 1, need);
                else           chk($sformatf("gap_min f%0d", lg[i].fid), (f - v - 1) >= need, 1);
            end
            if (lg[i].drop) begin
                chk($sformatf("drop_idle f%0d", lg[i].fid), wire_at(lg[i].k + 1), 10'd0);
            end else if (lg[i].m) begin
                chk($sformatf("wire1g f%0d b%0h", lg[i].fid, lg[i].d), wire_at(lg[i].k + 1),
                    exp_wire(lg[i].d, lg[i].e, 1'b1, 0));
                last_real = lg[i].k + 1;
            end else begin
                chk($sformatf("wire_lo f%0d b%0h", lg[i].fid, lg[i].d), wire_at(lg[i].k + 1),
                    exp_wire(lg[i].d, lg[i].e, 1'b0, 0));
                chk($sformatf("wire_hi f%0d b%0h", lg[i].fid, lg[i].d), wire_at(lg[i].k + 2),
                    exp_wire(lg[i].d, lg[i].e, 1'b0, 1));
                last_real = lg[i].k + 2;
            end
        end
    endtask

    task automatic fill_random(input int len);
        cur_d.delete();
        cur_e.delete();
        for (int j = 0; j < len; j++) begin
            cur_d.push_back(8'($urandom));
            cur_e.push_back($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   s;
        int   k;
        int   r;
        logic r0, r1, r2, r3;
        bit   b2b_next;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, {5'h15, 5'h1A}, 10'h000};
        tbl[1] = '{1'b1, 8'h3C, 1'b1, {5'h1C, 5'h03}, 10'h000};
        tbl[2] = '{1'b0, 8'hA5, 1'b1, {5'h15, 5'h05}, {5'h1A, 5'h0A}};
        tbl[3] = '{1'b0, 8'h7E, 1'b0, {5'h1E, 5'h1E}, {5'h17, 5'h17}};
        tbl[4] = '{1'b1, 8'hFF, 1'b0, {5'h1F, 5'h1F}, 10'h000};
        tbl[5] = '{1'b0, 8'h00, 1'b1, {5'h10, 5'h00}, {5'h10, 5'h00}};

        rst           = 1'b1;
        speed_1g      = 1'b1;
        phy_link_up   = 1'b1;
        gif.gmii_den  = 1'b0;
        gif.gmii_dout = 8'h00;
        gif.gmii_err  = 1'b0;

        // Reset behaviour
        repeat (3) begin
            @(negedge clk);
            chk("rdy_in_reset", gif.gmii_rdy, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("reset_wire", wire_at(cyc), 10'd0);
        chk("reset_rdy", gif.gmii_rdy, 1'b1);
        @(posedge clk);
        #1;

        // Single-byte frames from the vector table
        for (int i = 0; i < 6; i++) begin
            cur_d.delete();
            cur_e.delete();
            cur_d.push_back(tbl[i].d);
            cur_e.push_back(tbl[i].e);
            send_frame(tbl[i].spd, -1, 1'b0, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            k = lg[lg.size()-1].k;
            chk($sformatf("vec%0d_c1", i), wire_at(k + 1), tbl[i].w0);
            chk($sformatf("vec%0d_c2", i), wire_at(k + 2), tbl[i].w1);
        end

        // 10/100 ready pattern for one byte
        repeat (40) @(posedge clk);
        #1;
        speed_1g      = 1'b0;
        gif.gmii_den  = 1'b1;
        gif.gmii_dout = 8'hA5;
        gif.gmii_err  = 1'b1;
        @(negedge clk);
        r0 = gif.gmii_rdy;
        @(posedge clk);
        #1;
        gif.gmii_den = 1'b0;
        @(negedge clk);
        r1 = gif.gmii_rdy;
        @(negedge clk);
        r2 = gif.gmii_rdy;
        @(negedge clk);
        r3 = gif.gmii_rdy;
        chk("rdy_pattern_100m", {r0, r1, r2, r3}, 4'b1010);
        repeat (40) @(posedge clk);
        #1;

        // 64-byte ramp at 1G, then back-to-back frames across both modes
        s = lg.size();
        cur_d.delete();
        cur_e.delete();
        for (int j = 0; j < 64; j++) begin
            cur_d.push_back(8'(j));
            cur_e.push_back(1'b0);
        end
        send_frame(1'b1, -1, 1'b0, 1'b0);
        fill_random(8);
        send_frame(1'b1, -1, 1'b0, 1'b1);
        fill_random(5);
        send_frame(1'b0, -1, 1'b0, 1'b1);
        fill_random(5);
        send_frame(1'b0, -1, 1'b0, 1'b1);
        fill_random(3);
        send_frame(1'b1, -1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_from(s);

        // Link loss at byte 20 of 60, next frame after the gap
        s = lg.size();
        fill_random(60);
        send_frame(1'b1, 20, 1'b0, 1'b0);
        fill_random(10);
        send_frame(1'b1, -1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_from(s);

        // speed_1g wiggling mid-frame
        s = lg.size();
        fill_random(16);
        send_frame(1'b1, -1, 1'b1, 1'b0);
        fill_random(12);
        send_frame(1'b0, -1, 1'b1, 1'b1);
        fill_random(6);
        send_frame(1'b1, -1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_from(s);

        // Reset in the middle of a 1G frame
        repeat (40) @(posedge clk);
        #1;
        speed_1g = 1'b1;
        for (int j = 0; j < 10; j++) send_byte(8'h40 + 8'(j), 1'b0, k);
        gif.gmii_dout = 8'h4A;
        rst = 1'b1;
        #1;
        chk("rdy_low_in_reset", gif.gmii_rdy, 1'b0);
        @(posedge clk);
        #1;
        r = cyc;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        gif.gmii_den = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_last_byte", wire_at(r), exp_wire(8'h49, 1'b0, 1'b1, 0));
        chk("rst_wire_idle", wire_at(r + 1), 10'd0);
        chk("rst_wire_idle2", wire_at(r + 2), 10'd0);
        s = lg.size();
        fill_random(8);
        send_frame(1'b1, -1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_from(s);

        // Random frames, random modes, random gaps
        s        = lg.size();
        b2b_next = 0;
        for (int f = 0; f < 30; f++) begin
            fill_random($urandom_range(1, 16));
            send_frame(1'($urandom), -1, 1'b1, b2b_next);
            if ($urandom_range(0, 1) == 1) begin
                b2b_next = 1;
            end else begin
                b2b_next = 0;
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check_from(s);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
